// File: rtl/lcd_text_sched_if.sv
// Signal bundle between lcd_text_sched, the host logic and the LCD write engine.
// The slave modport is the scheduler's view; the master modport is the host/engine side.
interface lcd_text_sched_if;
    logic       buf_we;
    logic [5:0] buf_addr;
    logic [7:0] buf_wdata;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       wr_start;
    logic       wr_mode4;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_busy;
    logic       wr_done;
    logic       init_done;
    logic       frame_done;

    modport slave (
        input  buf_we, buf_addr, buf_wdata,
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output wr_start, wr_mode4, wr_rs, wr_data,
        input  wr_busy, wr_done,
        output init_done, frame_done
    );

    modport master (
        output buf_we, buf_addr, buf_wdata,
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  wr_start, wr_mode4, wr_rs, wr_data,
        output wr_busy, wr_done,
        input  init_done, frame_done
    );
endinterface

// File: rtl/lcd_text_sched.sv
// LCD text scheduler: runs the power-up byte sequence, then refreshes a 2-row
// character buffer forever, letting single host commands preempt at transfer boundaries.
module lcd_text_sched #(
    parameter int unsigned COLS      = 16,
    parameter int unsigned FRAME_GAP = 0
) (
    input  logic            clk,
    input  logic            reset,
    lcd_text_sched_if.slave bus
);

    localparam int unsigned DEPTH = 2 * COLS;
    localparam int unsigned BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = 6;
    localparam int unsigned GW    = $clog2(FRAME_GAP + 2);

    typedef enum logic [2:0] {
        S_INIT,
        S_ADDR0,
        S_ROW0,
        S_ADDR1,
        S_ROW1,
        S_GAP,
        S_CMD
    } state_t;

    state_t        state_q, state_d;
    logic          waiting_q, waiting_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    step_q, step_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend_q, pend_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;
    logic          start_q, start_d;
    logic          mode4_q, mode4_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    logic [7:0]    char_buf [DEPTH];
    logic [BW-1:0] rd_idx;
    logic [BW-1:0] wr_idx;
    logic          wr_in_range;

    logic          cmd_ready;
    logic          cmd_acc;
    logic          xfer_done;
    logic          last_col;
    logic          issue;
    logic [7:0]    pay_data;
    logic          pay_rs;
    logic          pay_mode4;

    assign cmd_ready   = init_done_q && !pend_q;
    assign cmd_acc     = bus.cmd_valid && cmd_ready;
    assign xfer_done   = waiting_q && bus.wr_done;
    assign last_col    = (col_q == CW'(COLS - 1));
    assign rd_idx      = BW'(col_q) + ((state_q == S_ROW1) ? BW'(COLS) : '0);
    assign wr_idx      = BW'(bus.buf_addr);
    assign wr_in_range = (32'(bus.buf_addr) < DEPTH);

    // Buffer read is combinational against the pre-edge contents, so a write
    // landing on the same edge as wr_start never reaches the byte being sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (bus.buf_we && wr_in_range) begin
            char_buf[wr_idx] <= bus.buf_wdata;
        end
    end

    always_comb begin
        pay_data  = 8'h00;
        pay_rs    = 1'b0;
        pay_mode4 = 1'b1;
        case (state_q)
            S_INIT: begin
                pay_mode4 = (step_q >= 3'd3);
                case (step_q)
                    3'd0, 3'd1, 3'd2: pay_data = 8'h33;
                    3'd3, 3'd4:       pay_data = 8'h28;
                    3'd5:             pay_data = 8'h06;
                    3'd6:             pay_data = 8'h0C;
                    default:          pay_data = 8'h01;
                endcase
            end
            S_ADDR0: pay_data = 8'h80;
            S_ADDR1: pay_data = 8'hC0;
            S_ROW0, S_ROW1: begin
                pay_data = char_buf[rd_idx];
                pay_rs   = 1'b1;
            end
            S_CMD:   pay_data = cmd_q;
            default: pay_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        waiting_d    = waiting_q;
        col_d        = col_q;
        step_d       = step_q;
        gap_d        = gap_q;
        pend_d       = pend_q;
        cmd_d        = cmd_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        start_d      = 1'b0;
        mode4_d      = mode4_q;
        rs_d         = rs_q;
        data_d       = data_q;
        issue        = 1'b0;

        if (cmd_acc) begin
            pend_d = 1'b1;
            cmd_d  = bus.cmd_data;
        end

        case (state_q)
            S_INIT: begin
                if (xfer_done) begin
                    waiting_d = 1'b0;
                    if (step_q == 3'd7) begin
                        init_done_d = 1'b1;
                        state_d     = S_ADDR0;
                        col_d       = '0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else if (!waiting_q && !bus.wr_busy) begin
                    issue = 1'b1;
                end
            end
            S_CMD: begin
                if (xfer_done) begin
                    waiting_d = 1'b0;
                    pend_d    = 1'b0;
                    state_d   = S_ADDR0;
                    col_d     = '0;
                end else if (!waiting_q && !bus.wr_busy) begin
                    issue = 1'b1;
                end
            end
            S_GAP: begin
                if (pend_d) begin
                    state_d = S_CMD;
                end else if (gap_q == GW'(FRAME_GAP)) begin
                    state_d = S_ADDR0;
                    col_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_ADDR0, S_ROW0, S_ADDR1, S_ROW1: begin
                // A pending command (even one accepted this very cycle) takes
                // the next transfer slot, abandoning the rest of the frame.
                if (xfer_done) begin
                    waiting_d = 1'b0;
                    if (pend_d) begin
                        state_d = S_CMD;
                    end else begin
                        case (state_q)
                            S_ADDR0: begin
                                state_d = S_ROW0;
                                col_d   = '0;
                            end
                            S_ROW0: begin
                                if (last_col) begin
                                    state_d = S_ADDR1;
                                    col_d   = '0;
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end
                            S_ADDR1: begin
                                state_d = S_ROW1;
                                col_d   = '0;
                            end
                            default: begin
                                if (last_col) begin
                                    state_d      = S_GAP;
                                    col_d        = '0;
                                    gap_d        = '0;
                                    frame_done_d = 1'b1;
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end
                        endcase
                    end
                end else if (!waiting_q) begin
                    if (pend_d) begin
                        state_d = S_CMD;
                    end else if (!bus.wr_busy) begin
                        issue = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        if (issue) begin
            start_d   = 1'b1;
            waiting_d = 1'b1;
            data_d    = pay_data;
            rs_d      = pay_rs;
            mode4_d   = pay_mode4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            waiting_q    <= 1'b0;
            col_q        <= '0;
            step_q       <= '0;
            gap_q        <= '0;
            pend_q       <= 1'b0;
            cmd_q        <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            start_q      <= 1'b0;
            mode4_q      <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            waiting_q    <= waiting_d;
            col_q        <= col_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            pend_q       <= pend_d;
            cmd_q        <= cmd_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            start_q      <= start_d;
            mode4_q      <= mode4_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.wr_start   = start_q;
    assign bus.wr_mode4   = mode4_q;
    assign bus.wr_rs      = rs_q;
    assign bus.wr_data    = data_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;

endmodule
